// File: rtl/ysyx_mem_arb.sv
// ysyx_mem_arb: arbitrates the fetch (IFU) and load/store (LSU) ports onto a
// single downstream memory port. Only one transaction is in flight at a time.
// The LSU normally wins, but a starvation counter hands the port to a waiting
// IFU after four consecutive LSU grants. A fetch that is flushed while it is
// outstanding still completes downstream, but its response is dropped.
`timescale 1ns/1ps

`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

module ysyx_mem_arb #(
  parameter int BIT_W = `YSYX_W_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  // fetch port
  input  logic             ifu_avalid,
  input  logic [BIT_W-1:0] ifu_addr,
  output logic             ifu_rvalid_o,
  output logic [BIT_W-1:0] ifu_rdata_o,
  input  logic             ifu_flush,
  // load/store port
  input  logic             lsu_avalid,
  input  logic [BIT_W-1:0] lsu_addr,
  input  logic             lsu_wen,
  input  logic [BIT_W-1:0] lsu_wdata,
  output logic             lsu_rvalid_o,
  output logic             lsu_wready_o,
  output logic [BIT_W-1:0] lsu_rdata_o,
  // downstream memory port
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [BIT_W-1:0] mem_addr_o,
  output logic [BIT_W-1:0] mem_wdata_o,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [BIT_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] STARVE_MAX = 3'd4;

  logic [1:0]       state;
  logic             owner_lsu;   // 1: LSU owns the transaction, 0: IFU
  logic             kill;        // outstanding fetch has been flushed
  logic [2:0]       starve_cnt;  // LSU grants won while the IFU was waiting
  logic [BIT_W-1:0] addr_q;
  logic [BIT_W-1:0] wdata_q;
  logic             wen_q;

  logic any_req;
  logic ifu_win;
  logic resp_fire;
  logic ifu_owned_flush;

  // Grant decision in IDLE: LSU first unless the IFU has been starved too long.
  always_comb begin
    any_req         = ifu_avalid | lsu_avalid;
    ifu_win         = ifu_avalid & (~lsu_avalid | (starve_cnt == STARVE_MAX));
    resp_fire       = (state == RESP) & mem_rvalid;
    ifu_owned_flush = ifu_flush & ~owner_lsu;
  end

  // Control FSM, ownership, kill flag and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_lsu  <= 1'b0;
      kill       <= 1'b0;
      starve_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (any_req) begin
            state     <= REQ;
            owner_lsu <= ~ifu_win;
            if (ifu_win) begin
              starve_cnt <= 3'd0;
            end else if (ifu_avalid && (starve_cnt != STARVE_MAX)) begin
              starve_cnt <= starve_cnt + 3'd1;
            end
          end
        end
        REQ: begin
          if (ifu_owned_flush) begin
            kill <= 1'b1;
          end
          if (mem_gnt) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            state <= IDLE;
            kill  <= 1'b0;
          end else if (ifu_owned_flush) begin
            kill <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          kill  <= 1'b0;
        end
      endcase
    end
  end

  // Command fields are captured once at grant so requester changes later on
  // cannot disturb the transaction in flight; they need no reset because they
  // are only observed while a granted transaction is active.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && any_req) begin
      addr_q  <= ifu_win ? ifu_addr : lsu_addr;
      wen_q   <= ifu_win ? 1'b0 : lsu_wen;
      wdata_q <= lsu_wdata;
    end
  end

  // Downstream command and same-cycle response routing to the owner.
  always_comb begin
    mem_req_o    = (state == REQ);
    mem_we_o     = wen_q;
    mem_addr_o   = addr_q;
    mem_wdata_o  = wdata_q;
    lsu_rvalid_o = resp_fire & owner_lsu & ~wen_q;
    lsu_wready_o = resp_fire & owner_lsu & wen_q;
    ifu_rvalid_o = resp_fire & ~owner_lsu & ~kill & ~ifu_flush;
    lsu_rdata_o  = mem_rdata;
    ifu_rdata_o  = mem_rdata;
  end

endmodule
